// File: rtl/pe_bit_alu_arbiter.sv
// Round-robin arbiter sharing one bit-wise ALU (OR/AND/XOR, zero/sign flags)
// among NREQ requesters, with a one-entry valid/ready result buffer.
module pe_bit_alu_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    CLK,
  input  logic                    ASYNCRESET,
  input  logic                    clk_en,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_data,
  output logic [IDW-1:0]          rsp_id,
  output logic                    rsp_z,
  output logic                    rsp_n,
  output logic [15:0]             done_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  buf_state_t       state;
  logic [IDW-1:0]   ptr;
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic             can_accept;
  logic             accept;
  logic             drain;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] alu_result;

  // First valid requester at or after ptr, wrapping NREQ-1 -> 0.
  always_comb begin : arbitrate
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    idx         = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  // Reset gating keeps req_ready low for the whole time reset is asserted.
  assign can_accept = clk_en & ~ASYNCRESET & ((state == EMPTY) | rsp_ready);
  assign accept     = can_accept & grant_found;
  assign drain      = clk_en & (state == FULL) & rsp_ready;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (IDW'(k) == grant_idx) begin
        sel_op = req_op[2*k +: 2];
        sel_a  = req_a[WIDTH*k +: WIDTH];
        sel_b  = req_b[WIDTH*k +: WIDTH];
      end
    end
  end

  always_comb begin
    case (sel_op)
      2'd0:    alu_result = sel_a | sel_b;
      2'd1:    alu_result = sel_a & sel_b;
      default: alu_result = sel_a ^ sel_b;
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state    <= EMPTY;
      ptr      <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_z    <= 1'b0;
      rsp_n    <= 1'b0;
      done_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (drain && done_cnt != 16'hFFFF) done_cnt <= done_cnt + 16'd1;
      if (accept) begin
        state    <= FULL;
        ptr      <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
        rsp_data <= alu_result;
        rsp_id   <= grant_idx;
        rsp_z    <= (alu_result == '0);
        rsp_n    <= alu_result[WIDTH-1];
      end else if (drain) begin
        state <= EMPTY;
      end
    end
  end

  assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_pe_bit_alu_arbiter.sv
// Scoreboard bench for pe_bit_alu_arbiter: a cycle-level reference model predicts
// grants and results; a separate monitor checks every drained response.
module tb_pe_bit_alu_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;

  logic                  CLK;
  logic                  ASYNCRESET;
  logic                  clk_en;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_z;
  logic                  rsp_n;
  logic [15:0]           done_cnt;

  pe_bit_alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .clk_en     (clk_en),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_z      (rsp_z),
    .rsp_n      (rsp_n),
    .done_cnt   (done_cnt)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    int               id;
    logic             z;
    logic             n;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_ptr;
  int   m_cnt;
  bit   m_full;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_alu(input int op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      0:       return a | b;
      1:       return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Reference model: predicts this cycle's grant and the buffer/counter effect of the next edge.
  initial begin
    int               w;
    bit               can;
    bit               drn;
    logic [NREQ-1:0]  exp_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    rsp_t             r;
    m_full = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    forever begin
      @(negedge CLK);
      if (ASYNCRESET) begin
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_done_cnt", done_cnt, 0);
        m_full = 0;
        m_ptr  = 0;
        m_cnt  = 0;
        exp_q.delete();
      end else begin
        check("rsp_valid", rsp_valid, m_full);
        check("done_cnt", done_cnt, m_cnt);
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        can = clk_en && (!m_full || rsp_ready);
        exp_ready = '0;
        if (can && w >= 0) exp_ready[w] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        drn = clk_en && m_full && rsp_ready;
        if (drn && m_cnt < 65535) m_cnt++;
        if (can && w >= 0) begin
          a      = req_a[WIDTH*w +: WIDTH];
          b      = req_b[WIDTH*w +: WIDTH];
          r.data = ref_alu(int'(req_op[2*w +: 2]), a, b);
          r.id   = w;
          r.z    = (r.data == 0);
          r.n    = r.data[WIDTH-1];
          exp_q.push_back(r);
          m_ptr  = (w + 1) % NREQ;
          m_full = 1;
        end else if (drn) begin
          m_full = 0;
        end
      end
    end
  end

  // Monitor: every handshake-completed response is matched against the oldest expectation.
  initial begin
    rsp_t r;
    forever begin
      @(negedge CLK);
      if (!ASYNCRESET && rsp_valid && rsp_ready && clk_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got data 0x%0h id %0d, expected no response", rsp_data, rsp_id);
        end else begin
          r = exp_q.pop_front();
          check("rsp_data", rsp_data, r.data);
          check("rsp_id", rsp_id, r.id);
          check("rsp_z", rsp_z, r.z);
          check("rsp_n", rsp_n, r.n);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int r, input int op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
    req_op[2*r +: 2]     = op[1:0];
    req_a[WIDTH*r +: WIDTH] = a;
    req_b[WIDTH*r +: WIDTH] = b;
  endtask

  // Single request, held until accepted, result left in the buffer.
  task automatic issue_one(input int r, input int op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_data,
                           input bit ez, input bit en);
    set_req(r, op, a, b);
    req_valid    = '0;
    req_valid[r] = 1'b1;
    rsp_ready    = 1'b0;
    @(negedge CLK);
    check("issue_grant", req_ready, 1 << r);
    step();
    req_valid = '0;
    @(negedge CLK);
    check("issue_valid", rsp_valid, 1);
    check("issue_data", rsp_data, exp_data);
    check("issue_id", rsp_id, r);
    check("issue_z", rsp_z, ez);
    check("issue_n", rsp_n, en);
    step();
  endtask

  task automatic drain_one();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    int grants[5] = '{0, 1, 2, 3, 0};
    int base;
    ASYNCRESET = 1'b1;
    clk_en     = 1'b1;
    rsp_ready  = 1'b0;
    req_valid  = '0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    step();
    step();
    ASYNCRESET = 1'b0;

    // Put a non-zero result into the buffer, then reset between edges.
    issue_one(0, 2, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 1);
    drain_one();
    issue_one(1, 0, 16'h1234, 16'h8000, 16'h9234, 0, 1);
    @(negedge CLK);
    #2 ASYNCRESET = 1'b1;
    #1;
    check("rst_now_valid", rsp_valid, 0);
    check("rst_now_data", rsp_data, 0);
    check("rst_now_id", rsp_id, 0);
    check("rst_now_z", rsp_z, 0);
    check("rst_now_n", rsp_n, 0);
    check("rst_now_cnt", done_cnt, 0);
    check("rst_now_ready", req_ready, 0);
    step();
    step();
    ASYNCRESET = 1'b0;

    issue_one(2, 1, 16'hF0F0, 16'h0FF0, 16'h00F0, 0, 0);
    drain_one();
    issue_one(0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0);
    drain_one();
    issue_one(1, 2, 16'h8001, 16'h0001, 16'h8000, 0, 1);
    drain_one();
    issue_one(3, 3, 16'h8001, 16'h0001, 16'h8000, 0, 1);
    drain_one();

    // Round-robin with all requesters valid and a free-running consumer.
    for (int r = 0; r < NREQ; r++) set_req(r, $urandom_range(0, 3), pick_operand(), pick_operand());
    req_valid = '1;
    rsp_ready = 1'b1;
    base      = m_cnt;
    foreach (grants[i]) begin
      @(negedge CLK);
      check("rr_grant", req_ready, 1 << grants[i]);
      step();
    end
    @(negedge CLK);
    check("rr_done_cnt", done_cnt, base + 4);
    step();

    // Backpressure: buffer holds requester 1's result, pointer now at 2.
    rsp_ready = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("bp_ready", req_ready, 0);
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, exp_q[0].data);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    check("bp_release_grant", req_ready, 4'b0100);
    step();

    // Enable low freezes everything even with the consumer ready.
    clk_en = 1'b0;
    base   = m_cnt;
    repeat (2) begin
      @(negedge CLK);
      check("ce_ready", req_ready, 0);
      check("ce_done_cnt", done_cnt, base);
      check("ce_valid", rsp_valid, 1);
      step();
    end
    clk_en = 1'b1;
    @(negedge CLK);
    check("ce_resume_grant", req_ready, 4'b1000);
    step();
    @(negedge CLK);
    check("ce_resume_done", done_cnt, base + 1);
    step();

    // Random traffic against the reference model.
    repeat (400) begin
      req_valid = NREQ'($urandom);
      for (int r = 0; r < NREQ; r++) set_req(r, $urandom_range(0, 3), pick_operand(), pick_operand());
      rsp_ready = ($urandom_range(0, 3) != 0);
      clk_en    = ($urandom_range(0, 7) != 0);
      step();
    end

    // Drive the completion counter past its ceiling.
    clk_en    = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    repeat (65540) step();
    @(negedge CLK);
    check("sat_done_cnt", done_cnt, 16'hFFFF);
    step();
    step();
    @(negedge CLK);
    check("sat_done_hold", done_cnt, 16'hFFFF);
    step();

    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();
    check("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
